// File: rtl/m_alu_core.sv
// Datapath for the multiply/divide unit: 33x33 signed multiplier, divider subtractor,
// and quotient/remainder select with negation. Purely combinational; clk/resetn are interface-only.

`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH 1
`endif
`ifndef MUX_MULTB_LENGTH
`define MUX_MULTB_LENGTH 1
`endif
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif
`ifndef MUX_MULTA_R_UNSIGNED
`define MUX_MULTA_R_UNSIGNED 0
`endif
`ifndef MUX_MULTA_R_SIGNED
`define MUX_MULTA_R_SIGNED 1
`endif
`ifndef MUX_DIV_REM_R
`define MUX_DIV_REM_R 0
`endif
`ifndef MUX_DIV_REM_Z
`define MUX_DIV_REM_Z 1
`endif

module m_alu_core (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [`MUX_MULTA_LENGTH-1:0]   mux_multA,
  input  logic [`MUX_MULTB_LENGTH-1:0]   mux_multB,
  input  logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
  input  logic [31:0]                    R,
  input  logic [62:0]                    D,
  input  logic [31:0]                    Z,
  output logic [31:0]                    sub_result,
  output logic [31:0]                    div_rem,
  output logic [31:0]                    div_rem_neg,
  output logic [63:0]                    product
);

  localparam logic [`MUX_MULTA_LENGTH-1:0] MULTA_SIGNED =
    `MUX_MULTA_LENGTH'(`MUX_MULTA_R_SIGNED);
  localparam logic [`MUX_MULTB_LENGTH-1:0] MULTB_SIGNED =
    `MUX_MULTB_LENGTH'(`MUX_MULTA_R_SIGNED);
  localparam logic [`MUX_DIV_REM_LENGTH-1:0] SEL_Z =
    `MUX_DIV_REM_LENGTH'(`MUX_DIV_REM_Z);

  logic        a_signed;
  logic        b_signed;
  logic [31:0] mult_b;
  logic [32:0] op_a;
  logic [32:0] op_b;
  logic [65:0] op_a_ext;
  logic [65:0] op_b_ext;
  logic [65:0] product_full;

  assign a_signed = (mux_multA == MULTA_SIGNED);
  assign b_signed = (mux_multB == MULTB_SIGNED);
  assign mult_b   = D[62:31];

  // A 33-bit signed operand covers both signed and unsigned 32-bit inputs,
  // so one signed multiplier serves MUL/MULH/MULHSU/MULHU.
  assign op_a = {a_signed & R[31], R};
  assign op_b = {b_signed & mult_b[31], mult_b};

  // Truncated two's-complement product of sign-extended operands equals the signed product.
  assign op_a_ext     = {{33{op_a[32]}}, op_a};
  assign op_b_ext     = {{33{op_b[32]}}, op_b};
  assign product_full = op_a_ext * op_b_ext;
  assign product      = product_full[63:0];

  assign sub_result  = R - D[31:0];
  assign div_rem     = (mux_div_rem == SEL_Z) ? Z : R;
  assign div_rem_neg = ~div_rem + 32'd1;

  logic unused_ok;
  assign unused_ok = &{1'b0, clk, resetn, product_full[65:64]};

endmodule

// File: tb/tb_m_alu_core.sv
// Randomized and directed checks of m_alu_core against a longint arithmetic model.

`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH 1
`endif
`ifndef MUX_MULTB_LENGTH
`define MUX_MULTB_LENGTH 1
`endif
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif
`ifndef MUX_MULTA_R_UNSIGNED
`define MUX_MULTA_R_UNSIGNED 0
`endif
`ifndef MUX_MULTA_R_SIGNED
`define MUX_MULTA_R_SIGNED 1
`endif
`ifndef MUX_DIV_REM_R
`define MUX_DIV_REM_R 0
`endif
`ifndef MUX_DIV_REM_Z
`define MUX_DIV_REM_Z 1
`endif

module tb_m_alu_core;

  logic                           clk;
  logic                           resetn;
  logic [`MUX_MULTA_LENGTH-1:0]   mux_multA;
  logic [`MUX_MULTB_LENGTH-1:0]   mux_multB;
  logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
  logic [31:0]                    R;
  logic [62:0]                    D;
  logic [31:0]                    Z;
  logic [31:0]                    sub_result;
  logic [31:0]                    div_rem;
  logic [31:0]                    div_rem_neg;
  logic [63:0]                    product;

  int checks = 0;
  int errors = 0;

  m_alu_core dut (
    .clk(clk), .resetn(resetn),
    .mux_multA(mux_multA), .mux_multB(mux_multB), .mux_div_rem(mux_div_rem),
    .R(R), .D(D), .Z(Z),
    .sub_result(sub_result), .div_rem(div_rem),
    .div_rem_neg(div_rem_neg), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic on the mathematical operand values.
  function automatic logic [63:0] ref_mul(input logic sa, input logic sb,
                                          input logic [31:0] a, input logic [31:0] b);
    longint av;
    longint bv;
    av = sa ? longint'($signed(a)) : longint'({32'd0, a});
    bv = sb ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(av * bv);
  endfunction

  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    longint diff;
    diff = longint'({32'd0, a}) - longint'({32'd0, b});
    return diff[31:0];
  endfunction

  function automatic logic [31:0] ref_neg(input logic [31:0] v);
    longint n;
    n = 64'h1_0000_0000 - longint'({32'd0, v});
    return n[31:0];
  endfunction

  task automatic drive(input logic sa, input logic sb, input logic selz,
                       input logic [31:0] r, input logic [31:0] mb,
                       input logic [30:0] dlo, input logic [31:0] z);
    @(negedge clk);
    mux_multA   = sa ? `MUX_MULTA_LENGTH'(`MUX_MULTA_R_SIGNED) : `MUX_MULTA_LENGTH'(`MUX_MULTA_R_UNSIGNED);
    mux_multB   = sb ? `MUX_MULTB_LENGTH'(`MUX_MULTA_R_SIGNED) : `MUX_MULTB_LENGTH'(`MUX_MULTA_R_UNSIGNED);
    mux_div_rem = selz ? `MUX_DIV_REM_LENGTH'(`MUX_DIV_REM_Z) : `MUX_DIV_REM_LENGTH'(`MUX_DIV_REM_R);
    R = r;
    D = {mb, dlo};
    Z = z;
    #1;
  endtask

  task automatic test_reset;
    logic [63:0] ep;
    resetn = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0003, 31'h1234, 32'h0000_0010);
    ep = ref_mul(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0003);
    checks++;
    if (product !== ep) begin
      errors++; $display("FAIL reset_product got=%h exp=%h", product, ep);
    end
    checks++;
    if (div_rem !== 32'h0000_0010 || div_rem_neg !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL reset_div_rem got=%h/%h exp=00000010/fffffff0", div_rem, div_rem_neg);
    end
    $display("reset: product=%h div_rem=%h", product, div_rem);
    // Toggle reset mid-operation: outputs must not move.
    @(posedge clk); #1 resetn = 1'b1;
    #2;
    checks++;
    if (product !== ep || sub_result !== ref_sub(32'hDEAD_BEEF, {1'b1, 31'h1234})) begin
      errors++; $display("FAIL reset_release got=%h/%h exp=%h", product, sub_result, ep);
    end
  endtask

  task automatic test_directed_mul;
    logic [63:0] exp_tab [5];
    logic        sa_tab  [5];
    logic        sb_tab  [5];
    logic [31:0] r_tab   [5];
    logic [31:0] b_tab   [5];
    sa_tab = '{0, 1, 1, 1, 1};
    sb_tab = '{0, 0, 0, 1, 1};
    r_tab  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    b_tab  = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    exp_tab = '{64'hFFFFFFFE00000001, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFF00000001,
                64'h4000000000000000, 64'h0000000000000001};
    for (int i = 0; i < 5; i++) begin
      drive(sa_tab[i], sb_tab[i], 1'b0, r_tab[i], b_tab[i], 31'($urandom), 32'($urandom));
      checks++;
      if (product !== exp_tab[i]) begin
        errors++; $display("FAIL mul_directed_%0d got=%h exp=%h", i, product, exp_tab[i]);
      end
      $display("mul directed %0d: sa=%0d sb=%0d R=%h B=%h product=%h", i, sa_tab[i], sb_tab[i],
               r_tab[i], b_tab[i], product);
    end
  endtask

  task automatic test_directed_sub_div;
    drive(1'b0, 1'b0, 1'b0, 32'd5, 32'($urandom) & 32'hFFFF_FFFE, 31'd7, 32'h0);
    checks++;
    if (sub_result !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL sub_5_minus_7 got=%h exp=fffffffe", sub_result);
    end
    $display("sub: R=5 D=7 sub_result=%h", sub_result);
    drive(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 31'h1234_5678, 32'h0);
    checks++;
    if (sub_result !== 32'h0) begin
      errors++; $display("FAIL sub_equal got=%h exp=00000000", sub_result);
    end
    // D[31] is also the low multiplier bit: exercise the shared bit.
    drive(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 31'h1234_5678, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h9234_5678, 32'h0000_0001, 31'h1234_5678, 32'h0);
    checks++;
    if (sub_result !== 32'h0 || product !== 64'h9234_5678) begin
      errors++; $display("FAIL shared_d31 got=%h/%h exp=00000000/0000000092345678", sub_result, product);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd1, 32'h0, 31'h0, 32'h5555_5555);
    checks++;
    if (div_rem !== 32'd1 || div_rem_neg !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divrem_r got=%h/%h exp=00000001/ffffffff", div_rem, div_rem_neg);
    end
    drive(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 31'h0, 32'h8000_0000);
    checks++;
    if (div_rem !== 32'h8000_0000 || div_rem_neg !== 32'h8000_0000) begin
      errors++; $display("FAIL divrem_z got=%h/%h exp=80000000/80000000", div_rem, div_rem_neg);
    end
    drive(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 31'h0, 32'h0);
    checks++;
    if (div_rem !== 32'h0 || div_rem_neg !== 32'h0) begin
      errors++; $display("FAIL divrem_zero got=%h/%h exp=00000000/00000000", div_rem, div_rem_neg);
    end
    $display("div_rem directed: last div_rem=%h neg=%h", div_rem, div_rem_neg);
  endtask

  task automatic test_random_mul;
    logic [31:0] r, b, z;
    logic        selz;
    logic [63:0] ep;
    logic [31:0] edr;
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 32; i++) begin
        r = $urandom; b = $urandom; z = $urandom; selz = 1'($urandom);
        if (i == 0) begin r = 32'h8000_0000; b = 32'h7FFF_FFFF; end
        drive(m[1], m[0], selz, r, b, 31'($urandom), z);
        ep  = ref_mul(m[1], m[0], r, b);
        edr = selz ? z : r;
        checks++;
        if (product !== ep) begin
          errors++; $display("FAIL mul_rand_m%0d_%0d got=%h exp=%h", m, i, product, ep);
        end
        checks++;
        if (div_rem !== edr || div_rem_neg !== ref_neg(edr)) begin
          errors++; $display("FAIL divrem_rand_m%0d_%0d got=%h/%h exp=%h/%h", m, i,
                             div_rem, div_rem_neg, edr, ref_neg(edr));
        end
        $display("mul rand m=%0d i=%0d R=%h B=%h product=%h", m, i, r, b, product);
      end
    end
  endtask

  task automatic test_random_sub;
    logic [31:0] r, z, es, edr;
    logic [31:0] mb;
    logic [30:0] dlo;
    logic        selz;
    for (int i = 0; i < 40; i++) begin
      r = $urandom; mb = $urandom; dlo = 31'($urandom); z = $urandom; selz = 1'($urandom);
      drive(1'($urandom), 1'($urandom), selz, r, mb, dlo, z);
      es  = ref_sub(r, {mb[0], dlo});
      edr = selz ? z : r;
      checks++;
      if (sub_result !== es) begin
        errors++; $display("FAIL sub_rand_%0d got=%h exp=%h", i, sub_result, es);
      end
      checks++;
      if (div_rem !== edr) begin
        errors++; $display("FAIL sub_divrem_%0d got=%h exp=%h", i, div_rem, edr);
      end
      $display("sub rand %0d: R=%h D=%h sub_result=%h", i, r, D, sub_result);
    end
  endtask

  initial begin
    resetn = 1'b0;
    mux_multA = '0; mux_multB = '0; mux_div_rem = '0;
    R = '0; D = '0; Z = '0;
    test_reset();
    test_directed_mul();
    test_directed_sub_div();
    test_random_mul();
    test_random_sub();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
